// File: rtl/op2bit_pkg.sv
// Shared defaults and shift-mode encoding for the op2bit shifter stage.
package op2bit_pkg;

  localparam int unsigned OP2BIT_WIDTH = 32;
  localparam int unsigned OP2BIT_SHAMT = 2;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_SRL  = 2'd1,
    MODE_SRA  = 2'd2,
    MODE_ROR  = 2'd3
  } shift_mode_e;

  // Priority decode: op gates everything, rotate overrides sra.
  function automatic shift_mode_e decode_mode(input logic op, input logic rotate,
                                              input logic sra);
    shift_mode_e mode;
    if (!op) begin
      mode = MODE_PASS;
    end else if (rotate) begin
      mode = MODE_ROR;
    end else if (sra) begin
      mode = MODE_SRA;
    end else begin
      mode = MODE_SRL;
    end
    return mode;
  endfunction

endpackage

// File: rtl/op2bit_core.sv
// Combinational mode decode and fixed-distance shift/rotate mux.
module op2bit_core
  import op2bit_pkg::*;
#(
  parameter int unsigned WIDTH = OP2BIT_WIDTH,
  parameter int unsigned SHAMT = OP2BIT_SHAMT
) (
  input  logic             i_sra,
  input  logic             i_rotate,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_result_c
);

  shift_mode_e w_mode;

  assign w_mode = decode_mode(i_op, i_rotate, i_sra);

  // Select pass-through or one of the three right-shift flavours.
  always_comb begin
    o_result_c = i_a;
    unique case (w_mode)
      MODE_PASS: o_result_c = i_a;
      MODE_SRL:  o_result_c = {{SHAMT{1'b0}}, i_a[WIDTH-1:SHAMT]};
      MODE_SRA:  o_result_c = {{SHAMT{i_a[WIDTH-1]}}, i_a[WIDTH-1:SHAMT]};
      MODE_ROR:  o_result_c = {i_a[SHAMT-1:0], i_a[WIDTH-1:SHAMT]};
      default:   o_result_c = i_a;
    endcase
  end

endmodule

// File: rtl/op2bit.sv
// Shift-by-SHAMT barrel-shifter stage with a registered output.
module op2bit
  import op2bit_pkg::*;
#(
  parameter int unsigned WIDTH = OP2BIT_WIDTH,
  parameter int unsigned SHAMT = OP2BIT_SHAMT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sra,
  input  logic             rotate,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out1
);

  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_out;

  op2bit_core #(
    .WIDTH (WIDTH),
    .SHAMT (SHAMT)
  ) u_core (
    .i_sra      (sra),
    .i_rotate   (rotate),
    .i_op       (op),
    .i_a        (a),
    .o_result_c (w_result)
  );

  // Output register; reset clears it immediately and discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_result;
    end
  end

  assign out1 = r_out;

endmodule

// File: tb/tb_op2bit.sv
// Scoreboard bench for op2bit: directed vectors, reset cases and random back-to-back traffic.
module tb_op2bit;

  logic        clk;
  logic        rst_n;
  logic        sra;
  logic        rotate;
  logic        op;
  logic [31:0] a;
  logic [31:0] out1;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        op;
    logic        rotate;
    logic        sra;
    logic [31:0] a;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  op2bit u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sra    (sra),
    .rotate (rotate),
    .op     (op),
    .a      (a),
    .out1   (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Independent reference: rotate via doubled word, arithmetic via signed shift.
  function automatic logic [31:0] model(input logic op_i, input logic rot_i,
                                        input logic sra_i, input logic [31:0] a_i);
    logic [63:0] aa;
    aa = {a_i, a_i};
    if (!op_i) return a_i;
    if (rot_i) return aa[33:2];
    if (sra_i) return 32'($signed(a_i) >>> 2);
    return a_i >> 2;
  endfunction

  // Drive one transaction after a falling edge and record its expected result.
  task automatic drive(input logic op_i, input logic rot_i, input logic sra_i,
                       input logic [31:0] a_i, input logic [31:0] exp_i);
    @(negedge clk);
    op = op_i;
    rotate = rot_i;
    sra = sra_i;
    a = a_i;
    exp_q.push_back(exp_i);
  endtask

  // Let the active edge pass, then compare the oldest expected value.
  task automatic collect(input string tag);
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, out1, e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h12345678, 32'h048D159E};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h01234567, 32'h0048D159};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'hABCDEF01, 32'h2AF37BC0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h87654321, 32'hE1D950C8};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h98765432, 32'hE61D950C};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h40000000, 32'h10000000};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'hFEDCBA98, 32'h3FB72EA6};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'hABCDEFFF, 32'hEAF37BFF};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'hC0FFEE01, 32'h703FFB80};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'hF0F0F0F0, 32'hF0F0F0F0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 32'hF0F0F0F0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h3FFFFFFF};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF};

    rst_n = 1'b1;
    op = 1'b1;
    rotate = 1'b0;
    sra = 1'b0;
    a = 32'hFFFFFFFF;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 check("reset_async", out1, 32'h0);
    @(posedge clk);
    #1 check("reset_hold", out1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, back-to-back.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rotate, vecs[i].sra, vecs[i].a, vecs[i].exp);
      collect($sformatf("vec%0d", i));
    end

    // Zero operand in every mode.
    for (int m = 0; m < 8; m++) begin
      logic [2:0] mb;
      mb = 3'(m);
      drive(mb[2], mb[1], mb[0], 32'h0, 32'h0);
      collect($sformatf("zero_m%0d", m));
    end

    // Positive operands: arithmetic must equal logical.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom() & 32'h7FFFFFFF;
      drive(1'b1, 1'b0, 1'b1, v, v >> 2);
      collect($sformatf("pos_sra%0d", i));
    end

    // Random back-to-back traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic        o_r, r_r, s_r;
      logic [31:0] v;
      o_r = 1'($urandom_range(0, 1));
      r_r = 1'($urandom_range(0, 1));
      s_r = 1'($urandom_range(0, 1));
      v = $urandom();
      drive(o_r, r_r, s_r, v, model(o_r, r_r, s_r, v));
      collect($sformatf("rand%0d", i));
    end

    // Mid-stream reset: a loaded result is cleared, a pending one discarded.
    drive(1'b1, 1'b1, 1'b0, 32'h89ABCDEF, model(1'b1, 1'b1, 1'b0, 32'h89ABCDEF));
    collect("pre_reset");
    @(negedge clk);
    op = 1'b0;
    a = 32'h5A5A5A5A;
    #2 rst_n = 1'b0;
    #1 check("reset_mid_async", out1, 32'h0);
    @(posedge clk);
    #1 check("reset_mid_hold", out1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    drive(1'b1, 1'b0, 1'b1, 32'h80000004, 32'hE0000001);
    collect("post_reset");
    drive(1'b0, 1'b0, 1'b0, 32'h13579BDF, 32'h13579BDF);
    collect("post_reset2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/op2bit.md
Name: op2bit

Overview:
- One stage of a right-shift/rotate datapath: conditionally shifts a 32-bit word right by a fixed 2 bit positions.
- Shift mode is logical, arithmetic or rotate.
- Used as the "shift-by-2" stage of a staged barrel shifter. The `op` bit is bit 1 of the shift amount, so the stage either shifts or passes `a` through.
- Output is registered. Latency is 1 clock.

Parameters:
- WIDTH, 32, data word width in bits; must be greater than SHAMT.
- SHAMT, 2, fixed shift distance of this stage in bit positions.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sra  input  1  1 = arithmetic right shift (sign fill); 0 = logical (zero fill)
- rotate  input  1  1 = rotate right; overrides sra
- op  input  1  1 = apply the shift/rotate; 0 = pass `a` unchanged
- a  input  WIDTH  operand
- out1  output  WIDTH  registered result

Behaviour:
- One clock domain (clk); single reset rst_n, asynchronous and active-low.
- Reset: `out1` is cleared to 0 immediately when rst_n falls and holds 0 while rst_n is low. Deassertion of rst_n is synchronised by the parent.
- Every rising clk edge with rst_n high: `out1 <= f(a, op, rotate, sra)`, sampled at that edge. Latency 1 cycle, throughput 1 per cycle, no handshake, no stall.
- Function f, in priority order:
  - op = 0: result = a. `sra` and `rotate` are ignored.
  - op = 1, rotate = 1: result = {a[SHAMT-1:0], a[WIDTH-1:SHAMT]}, i.e. rotate right by SHAMT. `sra` is ignored.
  - op = 1, rotate = 0, sra = 1: result = {SHAMT copies of a[WIDTH-1], a[WIDTH-1:SHAMT]}.
  - op = 1, rotate = 0, sra = 0: result = {SHAMT zeros, a[WIDTH-1:SHAMT]}.
- The result is purely bitwise: no overflow or status flags, and no dependence on past inputs.
- Boundary cases:
  - a = 0 with any mode: result 0.
  - a = all-ones: arithmetic and rotate give all-ones; logical gives 0x3FFFFFFF.
  - Positive operand (MSB = 0): arithmetic equals logical.
  - Reset asserted mid-stream: the pending result is discarded and `out1` becomes 0 at once. The first edge after release loads a fresh result.
- Inputs are assumed stable around the clk edge; no X-propagation handling is required.

Decomposition:
- Shared package: the WIDTH and SHAMT defaults, plus an enum for shift mode (PASS, SRL, SRA, ROR) decoded from op/rotate/sra.
- Natural single sub-module: `op2bit_core`, a combinational mode-decode and shift/rotate mux.
- `op2bit` wraps `op2bit_core` with the async-reset output register, so the parent shifter can chain multiple stages (1, 2, 4, 8, 16) by changing SHAMT.

Test Plan:
- Reset: hold rst_n=0, drive a=0xFFFFFFFF, op=1 → out1=0x00000000 with no clock edge needed. Assert rst_n mid-stream → out1 drops to 0 asynchronously.
- Logical: op=1, sra=0, rotate=0; a=0x12345678 → 0x048D159E; a=0x01234567 → 0x0048D159; a=0xABCDEF01 → 0x2AF37BC0. Each appears one cycle after apply.
- Arithmetic: op=1, sra=1, rotate=0; a=0x87654321 → 0xE1D950C8; a=0x98765432 → 0xE61D950C; a=0x40000000 → 0x10000000.
- Rotate with priority over sra: op=1, rotate=1; sra=1, a=0xFEDCBA98 → 0x3FB72EA6; sra=0, a=0xABCDEFFF → 0xEAF37BFF; sra=1, a=0xC0FFEE01 → 0x703FFB80.
- Pass-through: op=0, any sra/rotate, a=0xF0F0F0F0 → 0xF0F0F0F0.
- Back-to-back: change mode and operand every cycle. Check `out1` at edge N+1 equals f() of the inputs sampled at edge N, with no bubbles.
